// File: rtl/line_raster.sv
// Scanline vector rasteriser: draws each vector's span for the current row into a line buffer, then streams the row to a FIFO.
// Optional LINE_RASTER_BG_COLOR_EN adds a bg_color input used as the erase/background colour.
module line_raster #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 10,
  parameter int COLOR_W = 16,
  parameter int VEC_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic [VEC_W-1:0]   vector,
  output logic               read_vector,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] col,
  input  logic               last_vector,
  input  logic               trigger,
  output logic               frame_active,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [COLOR_W-1:0] fifo_data
`ifdef LINE_RASTER_BG_COLOR_EN
  ,
  input  logic [COLOR_W-1:0] bg_color
`endif
);

  // state | meaning
  // SYNC  | idle, waiting for trigger
  // CLEAR | blank pass after reset, fills the buffer with background, no FIFO writes
  // FETCH | read_vector high, vector list entry requested
  // SETUP | entry valid: sentinel check, row-range check, load stepping state
  // SPAN  | one Bresenham pixel per clock on the current row
  // COPY  | stream H_RES pixels to the FIFO, erasing behind the read
  typedef enum logic [2:0] {SYNC, CLEAR, FETCH, SETUP, SPAN, COPY} state_t;

  localparam int AW = $clog2(H_RES);
  localparam int EW = COORD_W + 2;
  localparam logic [VEC_W-1:0]   VEC_LAST = '1;
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(V_RES - 1);
  localparam logic [AW:0]        H_END    = (AW+1)'(H_RES);
  localparam logic [AW:0]        H_LAST   = (AW+1)'(H_RES - 1);
  localparam logic [COORD_W:0]   H_LIM    = (COORD_W+1)'(H_RES);

  state_t state;
  logic [COORD_W-1:0] scan_y;
  logic               need_clear;
  logic [COLOR_W-1:0] bg_in;
  logic [COLOR_W-1:0] bg_line;

  logic [COLOR_W-1:0] line_buf [H_RES];
  logic [H_RES-1:0]   pix_valid;
  logic [COORD_W+EW-1:0] st_ram [2**VEC_W];
  logic [COORD_W+EW-1:0] st_q;

  logic [COORD_W-1:0] cur_x, end_x, end_y, dx, dy;
  logic signed [EW-1:0] err;
  logic               sx_neg;
  logic [COLOR_W-1:0] span_col;

  logic [AW:0]        rd_addr;
  logic               p1_v, p1_px_valid, out_valid;
  logic [COLOR_W-1:0] p1_data, out_data;

  logic [COORD_W-1:0] dx_in, dy_in, x_next;
  logic signed [EW-1:0] err_init, err_next, dxe, dye;
  logic signed [EW:0] e2;
  logic step_x, step_y, at_end, visible, in_range, is_last;
  logic adv, issue, copy_done, wb_en;
  logic buf_we;
  logic [AW-1:0] buf_wa;
  logic [COLOR_W-1:0] buf_wd;

`ifdef LINE_RASTER_BG_COLOR_EN
  assign bg_in = bg_color;
`else
  assign bg_in = '0;
`endif

  assign fifo_write = out_valid && !fifo_full;
  assign fifo_data  = out_data;

  always_comb begin
    dx_in    = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy_in    = y1 - y0;
    err_init = $signed({2'b00, dx_in}) - $signed({2'b00, dy_in});
    in_range = (y1 >= y0) && (scan_y >= y0) && (scan_y <= y1);
    is_last  = last_vector || (vector == VEC_LAST);

    dxe      = $signed({2'b00, dx});
    dye      = $signed({2'b00, dy});
    e2       = {err, 1'b0};
    step_x   = e2 > -$signed({3'b000, dy});
    step_y   = e2 < $signed({3'b000, dx});
    err_next = err;
    if (step_x) err_next = err_next - dye;
    if (step_y) err_next = err_next + dxe;
    x_next   = cur_x;
    if (step_x) x_next = sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
    at_end   = (cur_x == end_x) && (scan_y == end_y);
    visible  = {1'b0, cur_x} < H_LIM;
    wb_en    = (state == SPAN) && !at_end && step_y;

    adv       = !out_valid || !fifo_full;
    issue     = (state == COPY) && adv && (rd_addr != H_END);
    copy_done = (state == COPY) && adv && (rd_addr == H_END) && !p1_v;

    buf_we = 1'b0;
    buf_wa = rd_addr[AW-1:0];
    buf_wd = bg_line;
    if (state == CLEAR) begin
      buf_we = 1'b1;
    end else if (state == SPAN && visible) begin
      buf_we = 1'b1;
      buf_wa = cur_x[AW-1:0];
      buf_wd = span_col;
    end else if (issue) begin
      buf_we = 1'b1;
    end
  end

  // Buffer read is read-first, so the erase write at the same address never hides the pixel.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[buf_wa] <= buf_wd;
    if (issue)  p1_data <= line_buf[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wb_en) st_ram[vector] <= {x_next, err_next};
    st_q <= st_ram[vector];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      scan_y       <= '0;
      vector       <= '0;
      read_vector  <= 1'b0;
      frame_active <= 1'b0;
      need_clear   <= 1'b1;
      bg_line      <= '0;
      pix_valid    <= '0;
      rd_addr      <= '0;
      p1_v         <= 1'b0;
      p1_px_valid  <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      cur_x        <= '0;
      err          <= '0;
      dx           <= '0;
      dy           <= '0;
      sx_neg       <= 1'b0;
      end_x        <= '0;
      end_y        <= '0;
      span_col     <= '0;
    end else if (trigger) begin
      // Clearing the valid map makes anything drawn before the abort invisible.
      frame_active <= 1'b1;
      scan_y       <= '0;
      vector       <= '0;
      pix_valid    <= '0;
      rd_addr      <= '0;
      p1_v         <= 1'b0;
      out_valid    <= 1'b0;
      bg_line      <= bg_in;
      if (need_clear) begin
        state       <= CLEAR;
        read_vector <= 1'b0;
      end else begin
        state       <= FETCH;
        read_vector <= 1'b1;
      end
    end else begin
      read_vector <= 1'b0;
      case (state)
        SYNC: ;
        CLEAR: begin
          if (rd_addr == H_LAST) begin
            rd_addr     <= '0;
            need_clear  <= 1'b0;
            bg_line     <= bg_in;
            state       <= FETCH;
            read_vector <= 1'b1;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        FETCH: state <= SETUP;
        SETUP: begin
          if (is_last) begin
            rd_addr <= '0;
            state   <= COPY;
          end else if (!in_range) begin
            vector      <= vector + 1'b1;
            read_vector <= 1'b1;
            state       <= FETCH;
          end else begin
            cur_x    <= (scan_y == y0) ? x0 : st_q[COORD_W+EW-1:EW];
            err      <= (scan_y == y0) ? err_init : $signed(st_q[EW-1:0]);
            dx       <= dx_in;
            dy       <= dy_in;
            sx_neg   <= x1 < x0;
            end_x    <= x1;
            end_y    <= y1;
            span_col <= col;
            state    <= SPAN;
          end
        end
        SPAN: begin
          if (visible) pix_valid[cur_x[AW-1:0]] <= 1'b1;
          if (at_end || step_y) begin
            vector      <= vector + 1'b1;
            read_vector <= 1'b1;
            state       <= FETCH;
          end else begin
            cur_x <= x_next;
            err   <= err_next;
          end
        end
        COPY: begin
          if (adv) begin
            p1_v      <= issue;
            out_valid <= p1_v;
            out_data  <= p1_px_valid ? p1_data : bg_line;
            if (issue) begin
              p1_px_valid                  <= pix_valid[rd_addr[AW-1:0]];
              pix_valid[rd_addr[AW-1:0]]   <= 1'b0;
              rd_addr                      <= rd_addr + 1'b1;
            end
          end
          if (copy_done) begin
            if (scan_y == LAST_Y) begin
              state        <= SYNC;
              frame_active <= 1'b0;
            end else begin
              scan_y      <= scan_y + 1'b1;
              vector      <= '0;
              bg_line     <= bg_in;
              read_vector <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster.sv
// Scoreboard bench for line_raster: expected pixels are queued per frame and a monitor pops one per FIFO write.
module tb_line_raster;
  localparam int H = 16;
  localparam int V = 4;
  localparam int CW = 6;
  localparam int COLW = 16;
  localparam int VW = 3;

  logic clk = 1'b0;
  logic rst;
  logic trigger;
  logic fifo_full = 1'b0;
  logic [VW-1:0] vector;
  logic read_vector;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [COLW-1:0] col = '0;
  logic last_vector = 1'b0;
  logic frame_active, fifo_write;
  logic [COLW-1:0] fifo_data;

  int checks = 0;
  int errors = 0;
  int total_writes = 0;
  logic bp_en = 1'b0;
  logic [COLW-1:0] exp_q [$];

  logic [CW-1:0] t_x0 [8], t_y0 [8], t_x1 [8], t_y1 [8];
  logic [COLW-1:0] t_col [8];
  logic t_last [8];
  logic [COLW-1:0] img [V][H];

  line_raster #(.H_RES(H), .V_RES(V), .COORD_W(CW), .COLOR_W(COLW), .VEC_W(VW)) dut (
    .clk(clk), .rst(rst), .vector(vector), .read_vector(read_vector),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .col(col), .last_vector(last_vector),
    .trigger(trigger), .frame_active(frame_active), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .fifo_data(fifo_data));

  initial forever #5 clk = ~clk;

  // Vector list source: answers a fetch with data valid the next cycle, held afterwards.
  always @(negedge clk) begin
    if (read_vector) begin
      x0 = t_x0[vector]; y0 = t_y0[vector];
      x1 = t_x1[vector]; y1 = t_y1[vector];
      col = t_col[vector]; last_vector = t_last[vector];
    end
  end

  initial forever begin
    @(posedge clk); #1;
    fifo_full = bp_en ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [COLW-1:0] e;
    forever begin
      @(negedge clk);
      if (fifo_write) begin
        total_writes++;
        checks++;
        if (fifo_full) begin
          errors++;
          $display("FAIL write_while_full: fifo_write=1 with fifo_full=1 at write %0d", total_writes);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: data=%h, required no write", fifo_data);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data !== e) begin
            errors++;
            $display("FAIL pixel write %0d: got %h required %h", total_writes, fifo_data, e);
          end
        end
      end
    end
  endtask

  task automatic set_vec(int i, int a, int b, int c, int d, int cc);
    t_x0[i] = CW'(a); t_y0[i] = CW'(b); t_x1[i] = CW'(c); t_y1[i] = CW'(d);
    t_col[i] = COLW'(cc); t_last[i] = 1'b0;
  endtask

  task automatic paint(int r, int lo, int hi, int c);
    for (int x = lo; x <= hi; x++) img[r][x] = COLW'(c);
  endtask

  // Scenes and their hand-derived row spans (later spans overwrite earlier ones).
  task automatic load_scene(int s);
    for (int i = 0; i < 8; i++) begin
      t_x0[i] = '0; t_y0[i] = '0; t_x1[i] = '0; t_y1[i] = '0; t_col[i] = '0; t_last[i] = 1'b1;
    end
    for (int r = 0; r < V; r++)
      for (int x = 0; x < H; x++) img[r][x] = '0;
    case (s)
      0: begin
        set_vec(0, 0, 0, 7, 2, 16'hAAAA);
        paint(0, 0, 1, 16'hAAAA); paint(1, 2, 5, 16'hAAAA); paint(2, 6, 7, 16'hAAAA);
      end
      1: begin
        set_vec(0, 9, 0, 7, 3, 5);
        paint(0, 9, 9, 5); paint(1, 8, 8, 5); paint(2, 8, 8, 5); paint(3, 7, 7, 5);
      end
      2: begin
        set_vec(0, 0, 1, 15, 1, 1); set_vec(1, 4, 1, 6, 1, 2);
        paint(1, 0, 15, 1); paint(1, 4, 6, 2);
      end
      default: begin
        set_vec(0, 10, 0, 30, 0, 7); set_vec(1, 5, 3, 8, 1, 9); set_vec(2, 12, 0, 20, 2, 3);
        paint(0, 10, 15, 7); paint(0, 12, 14, 3); paint(1, 15, 15, 3);
      end
    endcase
  endtask

  task automatic push_frame();
    for (int r = 0; r < V; r++)
      for (int x = 0; x < H; x++) exp_q.push_back(img[r][x]);
  endtask

  task automatic pulse_trigger();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic wait_frame(string name, int base);
    for (int i = 0; i < 4000; i++) begin
      if (!frame_active) break;
      @(posedge clk); #1;
    end
    chk({name, "_done"}, int'(frame_active), 0);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_leftover"}, exp_q.size(), 0);
    chk({name, "_writes"}, total_writes - base, H * V);
  endtask

  task automatic run_frame(int s, string name);
    int base;
    load_scene(s);
    base = total_writes;
    push_frame();
    pulse_trigger();
    chk({name, "_active"}, int'(frame_active), 1);
    wait_frame(name, base);
  endtask

  task automatic check_reset(string name);
    chk({name, "_vector"}, int'(vector), 0);
    chk({name, "_read_vector"}, int'(read_vector), 0);
    chk({name, "_fifo_write"}, int'(fifo_write), 0);
    chk({name, "_fifo_data"}, int'(fifo_data), 0);
    chk({name, "_frame_active"}, int'(frame_active), 0);
  endtask

  task automatic wait_writes(string name, int base, int n);
    for (int i = 0; i < 2000; i++) begin
      if (total_writes - base >= n) break;
      @(posedge clk); #1;
    end
    chk(name, int'(total_writes - base >= n), 1);
  endtask

  initial begin
    int base;
    fork
      monitor_loop();
    join_none
    rst = 1'b1;
    trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    run_frame(0, "basic");
    run_frame(1, "steep");
    run_frame(2, "overlap");
    run_frame(3, "clip");

    bp_en = 1'b1;
    run_frame(0, "backpressure");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);

    // Abort in the middle of line 2, then the restarted frame must be clean.
    load_scene(0);
    base = total_writes;
    push_frame();
    pulse_trigger();
    wait_writes("abort_reach_line2", base, 2 * H + 5);
    trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    chk("abort_vector", int'(vector), 0);
    chk("abort_read_vector", int'(read_vector), 1);
    chk("abort_frame_active", int'(frame_active), 1);
    exp_q.delete();
    base = total_writes;
    push_frame();
    wait_frame("abort_restart", base);

    // Reset in the middle of a copy, then idle with no writes, then a clean frame.
    load_scene(1);
    base = total_writes;
    push_frame();
    pulse_trigger();
    wait_writes("rst_reach_copy", base, H + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_mid");
    rst = 1'b0;
    exp_q.delete();
    base = total_writes;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_idle_writes", total_writes - base, 0);
    run_frame(1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Parametrised scanline vector rasteriser, successor to the current line engine.
- Per scanline: walks a vector list, draws each vector's horizontal span for the current row into an internal line buffer, then streams H_RES pixels to the video FIFO while erasing the buffer.
- New capabilities: all octants (x decreasing, steep lines), explicit reset, x-clipping, parametrised sizes, frame restart on trigger mid-frame.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, scanlines per frame.
- COORD_W, 10, coordinate width; H_RES and V_RES must both be at most 2^COORD_W.
- COLOR_W, 16, pixel/colour width.
- VEC_W, 10, vector index width; maximum list length is 2^VEC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- vector  out  VEC_W  vector index being fetched.
- read_vector  out  1  fetch enable; x0/y0/x1/y1/col/last_vector are valid the cycle after; the source holds them while read_vector=0.
- x0, y0  in  COORD_W each  start point.
- x1, y1  in  COORD_W each  end point; requires y1>=y0.
- col  in  COLOR_W  vector colour.
- last_vector  in  1  sentinel; this entry is not drawn.
- trigger  in  1  start of frame pulse.
- frame_active  out  1  high from trigger until the last line has been copied.
- fifo_full  in  1  FIFO backpressure.
- fifo_write  out  1  FIFO write strobe.
- fifo_data  out  COLOR_W  pixel data.

Behaviour:
- Reset: vector=0, read_vector=0, fifo_write=0, fifo_data=0, frame_active=0, FSM=SYNC, scan_y=0. Line buffer and per-vector state RAM are not reset; no stale pixel may be emitted, so the first post-reset frame clears while copying (see below).
- FSM states and transitions:
  - SYNC: on trigger, go to DRAW with scan_y=0.
  - DRAW: after the sentinel vector is consumed and the pipeline has drained, go to COPY.
  - COPY: after H_RES pixels are written, go to DRAW with scan_y+1; if scan_y=V_RES-1, go to SYNC and drop frame_active.
- Trigger in any state: abort, restart DRAW at scan_y=0 on the next cycle, reset vector to 0, drop any in-progress copy. Pixels already written to the FIFO stay written.
- Vector fetch: vector resets to 0 at every line start and increments once per accepted fetch. If vector reaches 2^VEC_W-1, that entry is treated as last.
- Drawn pixel set: the set of pixels visited by integer Bresenham over all octants.
  - dx=|x1-x0|, dy=y1-y0, sx=+1 if x1>=x0 else -1, err=dx-dy (signed, COORD_W+2 bits).
  - Loop: plot (x,y); stop at (x1,y1); e2=2*err; if e2>-dy then err-=dy, x+=sx; if e2<dx then err+=dx, y+=1.
  - On row scan_y, a vector contributes exactly those plotted pixels with y=scan_y.
- Per-vector state RAM (depth 2^VEC_W) holds x and err at the first pixel of the next row.
  - If scan_y==y0, state is initialised from x0 and dx-dy. If y0<scan_y<=y1, the stored state is used.
  - Vectors outside their row range, and vectors with y1<y0, plot nothing and do not write back.
  - Stale entries are harmless because every frame starts at row 0.
- Throughput: one pixel per clock during a span, plus at most 2 cycles of overhead per vector. State write-back occurs when the row is exited.
- Clipping: pixels with x>=H_RES are not written, but stepping continues.
- Priority: when pixels overlap, the higher vector index wins. The buffer initially holds 0.
- COPY: read buffer address 0..H_RES-1 in order, writing 0 behind each read.
  - One pixel per cycle while fifo_full=0; stall without loss while fifo_full=1.
  - fifo_write is never asserted while fifo_full=1. Read latency is 2 cycles.
- The first frame after reset: buffer contents are undefined until each address has been copied once. For that reason the initial SYNC→DRAW also runs one blank COPY pass with fifo_write held low.

Optional Feature:
- Macro LINE_RASTER_BG_COLOR_EN.
- Defined: adds input port bg_color[COLOR_W]. Copy-erase writes bg_color instead of 0, and the blank pass fills with bg_color, sampled at line start.
- Undefined: no port; background is 0.

Test Plan:
- H_RES=16, V_RES=4; vector0 (0,0)-(7,2) col=0xAAAA, vector1 sentinel → line0 x0..1, line1 x2..5, line2 x6..7 are 0xAAAA; all other pixels and line3 are 0; 64 FIFO writes total.
- Steep right-to-left (9,0)-(7,3), col=5 → exactly one pixel per row, at x=9, 8, 8, 7 (per Bresenham); others 0.
- Overlap: v0 (0,1)-(15,1) col=1, v1 (4,1)-(6,1) col=2 → line1 = 1,1,1,1,2,2,2,1…1.
- Clip/skip: (10,0)-(30,0) with H_RES=16 → x10..15 set and no spurious write-back; a vector with y1<y0 draws nothing.
- Backpressure: fifo_full toggled at random 50% during COPY → still exactly H_RES writes per line, in x order, none while full.
- trigger asserted mid-line 2 → next DRAW has scan_y=0, vector=0, and the output frame is identical to a clean frame; rst mid-COPY → outputs at their reset values the next cycle, no writes until the next trigger.
